// File: rtl/load_store_unit_if.sv
// Request/response, data-RAM and memory-mapped I/O signals of the load/store unit.
// No storage; pure wiring bundle.
// Backpressure: req_ready_o on the request side, none on the response side.
interface load_store_unit_if #(
  parameter int DMEM_AW = 15
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_we_i;
  logic [2:0]         req_funct3_i;
  logic [31:0]        req_addr_i;
  logic [31:0]        req_wdata_i;
  logic               rsp_valid_o;
  logic [31:0]        rsp_rdata_o;
  logic [1:0]         rsp_err_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [2:0]         dmem_funct3_o;
  logic [31:0]        dmem_wdata_o;
  logic               dmem_wr_en_o;
  logic [31:0]        dmem_rdata_i;
  logic               io_req_o;
  logic               io_we_o;
  logic [31:0]        io_addr_o;
  logic [31:0]        io_wdata_o;
  logic [3:0]         io_be_o;
  logic               io_ack_i;
  logic [31:0]        io_rdata_i;

  // Load/store unit side.
  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  dmem_rdata_i, io_ack_i, io_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output dmem_addr_o, dmem_funct3_o, dmem_wdata_o, dmem_wr_en_o,
    output io_req_o, io_we_o, io_addr_o, io_wdata_o, io_be_o
  );

  // Execute stage / memory environment side.
  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output dmem_rdata_i, io_ack_i, io_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  dmem_addr_o, dmem_funct3_o, dmem_wdata_o, dmem_wr_en_o,
    input  io_req_o, io_we_o, io_addr_o, io_wdata_o, io_be_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: checks legality, routes to data RAM or I/O bus, one response per request.
// Latency: error/RAM store 1 cycle, RAM load 2 cycles, I/O 1 cycle after ack or timeout.
// Backpressure: req_ready_o low while a load or I/O access is outstanding; responses cannot stall.
module load_store_unit #(
  parameter int         DMEM_AW    = 15,
  parameter logic [3:0] IO_BASE_HI = 4'hF,
  parameter int         IO_TIMEOUT = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DMEM_RD = 2'd1;
  localparam logic [1:0] ST_IO_WAIT = 2'd2;

  localparam int           CW       = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IO_TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_err;
  logic          io_req;
  logic          io_we;
  logic [31:0]   io_addr;
  logic [31:0]   io_wdata;
  logic [3:0]    io_be;
  logic [1:0]    io_off;
  logic [2:0]    io_f3;

  logic [1:0]    size;
  logic [1:0]    off;
  logic [1:0]    chk_err;
  logic          is_io;
  logic          accept;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;

  // Sign/zero-extend a right-aligned load value according to funct3.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = {{24{w[7] & ~f3[2]}}, w[7:0]};
      2'b01:   extend = {{16{w[15] & ~f3[2]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign size   = bus.req_funct3_i[1:0];
  assign off    = bus.req_addr_i[1:0];
  assign is_io  = (bus.req_addr_i[31:28] == IO_BASE_HI);
  assign accept = bus.req_valid_i & bus.req_ready_o;

  assign bus.req_ready_o   = (state == ST_IDLE) & ~rst_i;
  assign bus.dmem_addr_o   = bus.req_addr_i[DMEM_AW-1:0];
  assign bus.dmem_funct3_o = bus.req_funct3_i;
  assign bus.dmem_wdata_o  = bus.req_wdata_i;
  // RAM stores commit in the accept cycle; an erroring or I/O request never touches the RAM.
  assign bus.dmem_wr_en_o  = accept & bus.req_we_i & (chk_err == 2'b00) & ~is_io;

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.io_req_o    = io_req;
  assign bus.io_we_o     = io_we;
  assign bus.io_addr_o   = io_addr;
  assign bus.io_wdata_o  = io_wdata;
  assign bus.io_be_o     = io_be;

  // Legality check: illegal size has priority over misalignment.
  always_comb begin
    chk_err = 2'b00;
    if (size == 2'b11) begin
      chk_err = 2'b11;
    end else if ((size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00)) begin
      chk_err = 2'b01;
    end
  end

  // Byte enables and lane-shifted store data for the I/O bus.
  always_comb begin
    case (size)
      2'b00:   be_nxt = 4'b0001 << off;
      2'b01:   be_nxt = 4'b0011 << off;
      default: be_nxt = 4'b1111;
    endcase
    wdata_nxt = bus.req_wdata_i << {off, 3'b000};
  end

  // Request FSM, response register and I/O request/timeout tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_be     <= '0;
      io_off    <= 2'b00;
      io_f3     <= 3'b000;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (chk_err != 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= chk_err;
            end else if (is_io) begin
              io_req   <= 1'b1;
              io_we    <= bus.req_we_i;
              io_addr  <= {bus.req_addr_i[31:2], 2'b00};
              io_wdata <= wdata_nxt;
              io_be    <= be_nxt;
              io_off   <= off;
              io_f3    <= bus.req_funct3_i;
              cnt      <= '0;
              state    <= ST_IO_WAIT;
            end else if (bus.req_we_i) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 2'b00;
            end else begin
              state <= ST_DMEM_RD;
            end
          end
        end
        ST_DMEM_RD: begin
          // RAM data is already extended; just capture it.
          rsp_valid <= 1'b1;
          rsp_rdata <= bus.dmem_rdata_i;
          rsp_err   <= 2'b00;
          state     <= ST_IDLE;
        end
        ST_IO_WAIT: begin
          // An ack in the final timeout cycle still completes normally.
          if (bus.io_ack_i) begin
            io_req    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b00;
            rsp_rdata <= io_we ? 32'h0 : extend(bus.io_rdata_i >> {io_off, 3'b000}, io_f3);
            state     <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            io_req    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b10;
            rsp_rdata <= '0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner cases and random traffic.
// A byte-array RAM and a delayed-ack I/O responder stand in for the environment.
// Expected results come from constants or a word-level reference memory model.
module tb_load_store_unit;
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] io_rdata;
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
    logic        io;
    logic [31:0] io_addr;
    logic [3:0]  be;
    logic [31:0] io_wdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0]  ram  [0:32767];
  logic [31:0] gold [0:8191];

  vec_t tbl [0:18];
  vec_t rv;
  vec_t dummy;
  logic [31:0] r_addr;

  always #5 clk = ~clk;

  load_store_unit_if #(.DMEM_AW(15)) bus();

  load_store_unit #(
    .DMEM_AW(15),
    .IO_BASE_HI(4'hF),
    .IO_TIMEOUT(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
    logic [31:0] m;
    int bits;
    if (f3[1:0] >= 2'd2) return w;
    bits = 8 << f3[1:0];
    m = (32'h1 << bits) - 32'h1;
    if (!f3[2] && w[bits-1]) return w | ~m;
    return w & m;
  endfunction

  // Reference model: expected outcome of one request from the access rules alone.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int ack_at, input logic [31:0] ird);
    vec_t v;
    int sz;
    int o;
    logic [31:0] word;
    v = '{we, f3, a, wd, ack_at, ird, 2'b00, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    sz = 1 << f3[1:0];
    o = int'(a[1:0]);
    if (f3[1:0] == 2'b11) begin
      v.err = 2'b11;
    end else if ((a & 32'(sz - 1)) != 0) begin
      v.err = 2'b01;
    end else if (a[31:28] == 4'hF) begin
      v.io = 1'b1;
      v.io_addr = a & 32'hFFFF_FFFC;
      v.be = 4'(((1 << sz) - 1) << o);
      v.io_wdata = wd << (8 * o);
      if (ack_at >= 1 && ack_at <= 16) begin
        v.lat = ack_at + 1;
        if (!we) v.rdata = ext(ird >> (8 * o), f3);
      end else begin
        v.err = 2'b10;
        v.lat = 17;
      end
    end else if (we) begin
      word = gold[a[14:2]];
      for (int i = 0; i < sz; i++) word[8*(o+i) +: 8] = wd[8*i +: 8];
      gold[a[14:2]] = word;
    end else begin
      v.rdata = ext(gold[a[14:2]] >> (8 * o), f3);
      v.lat = 2;
    end
    return v;
  endfunction

  // Advance one clock; the bench RAM writes on the strobe and returns extended read data.
  task automatic cyc();
    logic w;
    logic [14:0] a;
    logic [2:0] f;
    logic [31:0] d;
    logic [31:0] word;
    int sz;
    w = bus.dmem_wr_en_o;
    a = bus.dmem_addr_o;
    f = bus.dmem_funct3_o;
    d = bus.dmem_wdata_o;
    sz = 1 << f[1:0];
    word = {ram[{a[14:2], 2'b11}], ram[{a[14:2], 2'b10}], ram[{a[14:2], 2'b01}], ram[{a[14:2], 2'b00}]};
    @(posedge clk);
    #1;
    bus.dmem_rdata_i = ext(word >> (8 * int'(a[1:0])), f);
    if (w) for (int i = 0; i < sz; i++) ram[a + 15'(i)] = d[8*i +: 8];
    @(negedge clk);
  endtask

  // Issue one request while idle, serve the I/O side, and check the response.
  task automatic run_req(input vec_t v);
    int lat;
    int seen;
    bit got;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = v.we;
    bus.req_funct3_i = v.f3;
    bus.req_addr_i   = v.addr;
    bus.req_wdata_i  = v.wdata;
    bus.io_ack_i     = 1'b0;
    #1;
    chk("accept_ready", {31'h0, bus.req_ready_o}, 32'h1);
    chk("dmem_wr_en", {31'h0, bus.dmem_wr_en_o}, {31'h0, v.we & (v.err == 2'b00) & ~v.io});
    chk("dmem_addr", {17'h0, bus.dmem_addr_o}, {17'h0, v.addr[14:0]});
    cyc();
    bus.req_valid_i = 1'b0;
    lat = 0;
    seen = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      lat++;
      if (bus.io_req_o) begin
        seen++;
        bus.io_ack_i = (seen == v.ack_at);
        bus.io_rdata_i = bus.io_ack_i ? v.io_rdata : $urandom;
        if (seen == 1) begin
          chk("io_addr", bus.io_addr_o, v.io_addr);
          chk("io_be", {28'h0, bus.io_be_o}, {28'h0, v.be});
          chk("io_wdata", bus.io_wdata_o, v.io_wdata);
          chk("io_we", {31'h0, bus.io_we_o}, {31'h0, v.we});
        end
      end else begin
        bus.io_ack_i = 1'b0;
      end
      #1;
      if (bus.rsp_valid_o) begin
        got = 1'b1;
        chk("latency", lat, v.lat);
        chk("rsp_err", {30'h0, bus.rsp_err_o}, {30'h0, v.err});
        chk("rsp_rdata", bus.rsp_rdata_o, v.rdata);
        chk("io_req_done", {31'h0, bus.io_req_o}, 32'h0);
      end else begin
        chk("busy_ready", {31'h0, bus.req_ready_o}, 32'h0);
        chk("io_req_state", {31'h0, bus.io_req_o}, {31'h0, v.io});
        cyc();
      end
    end
    bus.io_ack_i = 1'b0;
    if (!got) chk("rsp_arrived", 32'h0, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    for (int i = 0; i < 8192; i++) gold[i] = 32'h0;

    tbl[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 2'b00, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'h0, 2'b00, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 3'b010, 32'h0000_0020, 32'h0000_80FF, 0, 32'h0, 2'b00, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[3]  = '{1'b0, 3'b000, 32'h0000_0021, 32'h0, 0, 32'h0, 2'b00, 32'hFFFF_FF80, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 3'b100, 32'h0000_0021, 32'h0, 0, 32'h0, 2'b00, 32'h0000_0080, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 3'b001, 32'h0000_0003, 32'h1234, 0, 32'h0, 2'b01, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[6]  = '{1'b0, 3'b011, 32'h0000_0040, 32'h0, 0, 32'h0, 2'b11, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 3'b001, 32'hF000_0006, 32'h0, 4, 32'h8001_0000, 2'b00, 32'hFFFF_8001, 5, 1'b1, 32'hF000_0004, 4'b1100, 32'h0};
    tbl[8]  = '{1'b1, 3'b010, 32'hF000_0000, 32'h1234_5678, 0, 32'h0, 2'b10, 32'h0, 17, 1'b1, 32'hF000_0000, 4'b1111, 32'h1234_5678};
    tbl[9]  = '{1'b1, 3'b010, 32'hF000_0000, 32'h1234_5678, 16, 32'h0, 2'b00, 32'h0, 17, 1'b1, 32'hF000_0000, 4'b1111, 32'h1234_5678};
    tbl[10] = '{1'b0, 3'b010, 32'h0000_8010, 32'h0, 0, 32'h0, 2'b00, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[11] = '{1'b0, 3'b010, 32'h7000_0010, 32'h0, 0, 32'h0, 2'b00, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 3'b000, 32'hF000_0003, 32'h0, 1, 32'hA500_0000, 2'b00, 32'hFFFF_FFA5, 2, 1'b1, 32'hF000_0000, 4'b1000, 32'h0};
    tbl[13] = '{1'b1, 3'b000, 32'hF000_0002, 32'h0000_00AB, 2, 32'h0, 2'b00, 32'h0, 3, 1'b1, 32'hF000_0000, 4'b0100, 32'h00AB_0000};
    tbl[14] = '{1'b0, 3'b010, 32'hF000_0002, 32'h0, 0, 32'h0, 2'b01, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[15] = '{1'b0, 3'b001, 32'h0000_0020, 32'h0, 0, 32'h0, 2'b00, 32'hFFFF_80FF, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[16] = '{1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 0, 32'h0, 2'b00, 32'h0, 1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[17] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0, 0, 32'h0, 2'b00, 32'hBEEF_80FF, 2, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[18] = '{1'b0, 3'b110, 32'h0000_0024, 32'h0, 0, 32'h0, 2'b00, 32'h0, 2, 1'b0, 32'h0, 4'h0, 32'h0};

    rst = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    bus.dmem_rdata_i = 32'h0;
    bus.io_ack_i     = 1'b0;
    bus.io_rdata_i   = 32'h0;

    // Reset state, with a store presented while reset is held.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_funct3_i = 3'b010;
    bus.req_addr_i  = 32'h0000_0010;
    #1;
    chk("rst_ready", {31'h0, bus.req_ready_o}, 32'h0);
    chk("rst_wr_en", {31'h0, bus.dmem_wr_en_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", {30'h0, bus.rsp_err_o}, 32'h0);
    chk("rst_io_req", {31'h0, bus.io_req_o}, 32'h0);
    chk("rst_io_we", {31'h0, bus.io_we_o}, 32'h0);
    chk("rst_io_addr", bus.io_addr_o, 32'h0);
    chk("rst_io_wdata", bus.io_wdata_o, 32'h0);
    chk("rst_io_be", {28'h0, bus.io_be_o}, 32'h0);
    bus.req_valid_i = 1'b0;
    cyc();
    rst = 1'b0;

    // Directed vectors; consecutive entries also exercise accept-on-response-cycle.
    for (int i = 0; i < 19; i++) begin
      dummy = model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].ack_at, tbl[i].io_rdata);
      run_req(tbl[i]);
    end

    // Response pulse lasts exactly one cycle.
    cyc();
    #1;
    chk("rsp_pulse_width", {31'h0, bus.rsp_valid_o}, 32'h0);

    // Reset while an I/O request is waiting: no response, ready right after release.
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'b010;
    bus.req_addr_i   = 32'hF000_0000;
    bus.req_wdata_i  = 32'hCAFE_F00D;
    #1;
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    cyc();
    #1;
    chk("midio_io_req", {31'h0, bus.io_req_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midio_io_req_drop", {31'h0, bus.io_req_o}, 32'h0);
    chk("midio_ready_rst", {31'h0, bus.req_ready_o}, 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("midio_ready_release", {31'h0, bus.req_ready_o}, 32'h1);
    chk("midio_no_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
    for (int i = 0; i < 18; i++) begin
      cyc();
      #1;
      chk("midio_no_late_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      r_addr = $urandom;
      r_addr[14:6] = 9'h0;
      if ($urandom_range(0, 3) == 0) r_addr[31:28] = 4'hF;
      else if (r_addr[31:28] == 4'hF) r_addr[31:28] = 4'h3;
      rv = model(1'($urandom), 3'($urandom), r_addr, $urandom, $urandom_range(0, 20), $urandom);
      run_req(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
